sprite_pixel_scheduler: RTL
===========================

SPRITE_PIXEL_SCHEDULER -- requirements
Module: sprite_pixel_scheduler

Interface
REQ-001 Clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-002 Reset_n  input  1  asynchronous, active-low reset.
REQ-003 DrawX, DrawY  input  10 each  current raster coordinate, 640x480 visible area.
REQ-004 pix_valid  input  1  DrawX/DrawY lie in the visible area this cycle.
REQ-005 frame_start  input  1  one-cycle pulse during vertical blanking, once per frame.
REQ-006 start_req, lose_req, win_req  input  1 each  game events; each is a level held for at least one cycle.
REQ-007 level  input  2  requested dungeon, 1..3; value 0 is treated as 1.
REQ-008 char_x/char_y, mon_x/mon_y, key_x/key_y, bul_x/bul_y  input  10 each  sprite top-left corners in screen pixels.
REQ-009 key_en, bul_en  input  1 each  key sprite and bullet sprite are present.
REQ-010 bg_data, char_data, mon_data, key_data, bul_data  input  4 each  RAM read data, one cycle after the address.
REQ-011 bg_addr, char_addr, mon_addr, key_addr, bul_addr  output  19 each  registered RAM read addresses.
REQ-012 screen_sel  output  3  full-screen RAM select: 0 initial, 1-3 dungeon 1-3, 4 game-over, 5 you-win.
REQ-013 char_frame  output  1  selects the rouge (0) or rouge1 (1) character RAM.
REQ-014 color_idx  output  4  composited palette index; pix_valid_out  output  1  color_idx is valid.
REQ-015 mode  output  2  0 INIT, 1 PLAY, 2 FAIL, 3 WIN.

Function
REQ-016 Mode FSM: INIT->PLAY on start_req; PLAY->FAIL on lose_req; PLAY->WIN on win_req; FAIL or WIN->INIT on start_req.
REQ-017 Simultaneous lose_req and win_req in PLAY SHALL resolve to FAIL.
REQ-018 Each FSM transition SHALL be latched as pending and applied only in a cycle where frame_start=1.
REQ-019 Only the first transition requested in a frame SHALL be kept.
REQ-020 On entry to PLAY, level SHALL be sampled into an internal register.
REQ-021 screen_sel SHALL be derived from mode and the latched level, and SHALL change only on a frame_start cycle.
REQ-022 Pipeline stage 1 (one cycle after DrawX/DrawY are sampled) SHALL register all of the following:
  - bg_addr = (DrawY>>1)*320 + (DrawX>>1), range 0..76799;
  - character, monster and key addresses = (DrawY-y)*35 + (DrawX-x), sprite size 35x60, range 0..2099;
  - bul_addr = (DrawY-y)*5 + (DrawX-x), sprite size 5x5, range 0..24;
  - the per-sprite hit flags and pix_valid.
REQ-023 Hit SHALL require x<=DrawX<x+w and y<=DrawY<y+h, evaluated with 11-bit unsigned arithmetic so that a sprite near X=639 does not wrap.
REQ-024 When a sprite is not hit, its address SHALL be 0.
REQ-025 Hit flags and pix_valid SHALL be delayed one further stage to align with the RAM data.
REQ-026 Stage 3 SHALL register color_idx and pix_valid_out, for a total latency of 3 cycles from DrawX/DrawY to color_idx.
REQ-027 Compositing priority, highest first: bullet, character, monster, key, background.
REQ-028 A sprite SHALL contribute only if its delayed hit flag=1 and its data is non-zero; index 0 is transparent.
REQ-029 The bullet SHALL contribute only if bul_en=1, and the key only if key_en=1.
REQ-030 In INIT, FAIL and WIN modes, all sprite hits SHALL be forced to 0 and color_idx=bg_data.
REQ-031 When the delayed pix_valid=0, color_idx SHALL be 0 and pix_valid_out SHALL be 0.
REQ-032 A 4-bit frame counter SHALL increment on every frame_start while mode=PLAY.
REQ-033 char_frame SHALL toggle when the frame counter wraps from 15 to 0, i.e. every 16 frames.
REQ-034 The frame counter and char_frame SHALL be cleared on entry to PLAY.
REQ-035 The block SHALL never assert any RAM write enable; it is read-only.

Reset
REQ-036 While Reset_n=0, regardless of Clk:
  - mode=INIT, screen_sel=0, latched level=1;
  - pending transition cleared;
  - frame counter=0, char_frame=0;
  - all addresses=0, all pipeline valids=0, color_idx=0, pix_valid_out=0.
REQ-037 Reset asserted mid-frame or mid-pipeline SHALL discard all in-flight pixels; the first valid output SHALL occur 3 cycles after the first pix_valid sampled post-reset.

Verification
REQ-038 Reset, then DrawX=100, DrawY=50, pix_valid=1 -> bg_addr=25*320+50=8050 at cycle 1; color_idx=bg_data and pix_valid_out=1 at cycle 3.
REQ-039 PLAY, char at (100,50), DrawX=110, DrawY=60, char_data=7, bul_en=0 -> char_addr=360; color_idx=7. Repeat with char_data=0 -> color_idx=bg_data.
REQ-040 PLAY, bullet at (110,60), bul_en=1, bul_data=3, overlapping character with char_data=7 -> color_idx=3. Repeat with bul_en=0 -> color_idx=7.
REQ-041 start_req mid-frame with level=2 -> mode and screen_sel stay at 0 until frame_start, then mode=1, screen_sel=2. Then lose_req and win_req in the same cycle -> next frame_start gives mode=2, screen_sel=4.
REQ-042 PLAY for 32 frame_start pulses -> char_frame toggles exactly twice. Sprite at x=630, DrawX=5 -> no hit; x=630, DrawX=639 -> hit with address offset 9.

Source files
------------

// File: rtl/sprite_pixel_scheduler.sv
// sprite_pixel_scheduler
//   Game-mode FSM, frame-synchronous screen selection, character animation
//   frame toggling, and a 3-stage pixel pipeline that generates sprite and
//   background RAM read addresses and composites the returned palette indices.
//
// Ports
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   DrawX, DrawY, pix_valid      raster coordinate and visible-area flag
//   frame_start                  one pulse per frame during vertical blank
//   start_req/lose_req/win_req   game events (levels)
//   level                        requested dungeon 1..3 (0 treated as 1)
//   *_x/*_y, key_en, bul_en      sprite positions and presence
//   *_data                       RAM read data, one cycle after *_addr
//   *_addr                       registered RAM read addresses
//   screen_sel, char_frame       full-screen RAM select, character RAM select
//   color_idx, pix_valid_out     composited palette index, valid 3 cycles later
//   mode                         0 INIT, 1 PLAY, 2 FAIL, 3 WIN
module sprite_pixel_scheduler (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic        start_req,
  input  logic        lose_req,
  input  logic        win_req,
  input  logic [1:0]  level,
  input  logic [9:0]  char_x,
  input  logic [9:0]  char_y,
  input  logic [9:0]  mon_x,
  input  logic [9:0]  mon_y,
  input  logic [9:0]  key_x,
  input  logic [9:0]  key_y,
  input  logic [9:0]  bul_x,
  input  logic [9:0]  bul_y,
  input  logic        key_en,
  input  logic        bul_en,
  input  logic [3:0]  bg_data,
  input  logic [3:0]  char_data,
  input  logic [3:0]  mon_data,
  input  logic [3:0]  key_data,
  input  logic [3:0]  bul_data,
  output logic [18:0] bg_addr,
  output logic [18:0] char_addr,
  output logic [18:0] mon_addr,
  output logic [18:0] key_addr,
  output logic [18:0] bul_addr,
  output logic [2:0]  screen_sel,
  output logic        char_frame,
  output logic [3:0]  color_idx,
  output logic        pix_valid_out,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    MODE_INIT = 2'd0,
    MODE_PLAY = 2'd1,
    MODE_FAIL = 2'd2,
    MODE_WIN  = 2'd3
  } mode_e;

  // hit vector bit positions
  localparam int unsigned H_CHAR = 0;
  localparam int unsigned H_MON  = 1;
  localparam int unsigned H_KEY  = 2;
  localparam int unsigned H_BUL  = 3;

  // ---------------------------------------------------------------- mode FSM
  mode_e       mode_q, mode_d, req_mode, nxt_mode, pend_mode_q, pend_mode_d;
  logic        req_vld, pend_vld_q, pend_vld_d;
  logic [1:0]  lvl_q, lvl_d;
  logic [2:0]  sel_q, sel_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        cf_q, cf_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q      <= MODE_INIT;
      pend_vld_q  <= 1'b0;
      pend_mode_q <= MODE_INIT;
      lvl_q       <= 2'd1;
      sel_q       <= '0;
      fcnt_q      <= '0;
      cf_q        <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pend_vld_q  <= pend_vld_d;
      pend_mode_q <= pend_mode_d;
      lvl_q       <= lvl_d;
      sel_q       <= sel_d;
      fcnt_q      <= fcnt_d;
      cf_q        <= cf_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    pend_vld_d  = pend_vld_q;
    pend_mode_d = pend_mode_q;
    lvl_d       = lvl_q;
    sel_d       = sel_q;
    fcnt_d      = fcnt_q;
    cf_d        = cf_q;
    req_vld     = 1'b0;
    req_mode    = mode_q;

    case (mode_q)
      MODE_INIT: if (start_req) begin req_vld = 1'b1; req_mode = MODE_PLAY; end
      MODE_PLAY: begin
        // lose wins a tie with win
        if (lose_req)     begin req_vld = 1'b1; req_mode = MODE_FAIL; end
        else if (win_req) begin req_vld = 1'b1; req_mode = MODE_WIN;  end
      end
      default:   if (start_req) begin req_vld = 1'b1; req_mode = MODE_INIT; end
    endcase

    // a held-over pending request takes precedence over anything newer
    nxt_mode = pend_vld_q ? pend_mode_q : req_mode;

    if (frame_start) begin
      pend_vld_d = 1'b0;
      if (mode_q == MODE_PLAY) begin
        fcnt_d = fcnt_q + 4'd1;
        if (fcnt_q == 4'hF) cf_d = ~cf_q;
      end
      if (pend_vld_q || req_vld) begin
        mode_d = nxt_mode;
        if (nxt_mode == MODE_PLAY) begin
          lvl_d  = (level == 2'd0) ? 2'd1 : level;
          fcnt_d = '0;
          cf_d   = 1'b0;
        end
      end
      case (mode_d)
        MODE_INIT: sel_d = 3'd0;
        MODE_PLAY: sel_d = {1'b0, lvl_d};
        MODE_FAIL: sel_d = 3'd4;
        default:   sel_d = 3'd5;
      endcase
    end else if (!pend_vld_q && req_vld) begin
      pend_vld_d  = 1'b1;
      pend_mode_d = req_mode;
    end
  end

  // ---------------------------------------------------------- pixel pipeline
  // 11-bit compare keeps x+w from wrapping for sprites near the right edge
  function automatic logic spr_hit(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] sx, input logic [9:0] sy,
                                   input logic [10:0] w, input logic [10:0] h);
    logic [10:0] px11, py11, sx11, sy11;
    px11 = {1'b0, px};
    py11 = {1'b0, py};
    sx11 = {1'b0, sx};
    sy11 = {1'b0, sy};
    return (px11 >= sx11) && (px11 < sx11 + w) && (py11 >= sy11) && (py11 < sy11 + h);
  endfunction

  function automatic logic [18:0] spr_off(input logic [9:0] px, input logic [9:0] py,
                                          input logic [9:0] sx, input logic [9:0] sy,
                                          input logic [18:0] w);
    logic [9:0] dx, dy;
    dx = px - sx;
    dy = py - sy;
    return {9'd0, dy} * w + {9'd0, dx};
  endfunction

  logic        play;
  logic [3:0]  hit_s;
  logic [18:0] bg_addr_q, ch_addr_q, mn_addr_q, ky_addr_q, bl_addr_q;
  logic [3:0]  hit1_q, hit2_q;
  logic        vld1_q, vld2_q;
  logic [3:0]  color_q, color_d;
  logic        pvo_q;

  always_comb begin
    play          = (mode_q == MODE_PLAY);
    hit_s         = '0;
    hit_s[H_CHAR] = play && spr_hit(DrawX, DrawY, char_x, char_y, 11'd35, 11'd60);
    hit_s[H_MON]  = play && spr_hit(DrawX, DrawY, mon_x,  mon_y,  11'd35, 11'd60);
    hit_s[H_KEY]  = play && spr_hit(DrawX, DrawY, key_x,  key_y,  11'd35, 11'd60);
    hit_s[H_BUL]  = play && spr_hit(DrawX, DrawY, bul_x,  bul_y,  11'd5,  11'd5);
  end

  always_comb begin
    color_d = bg_data;
    if (!vld2_q)                                             color_d = '0;
    else if (hit2_q[H_BUL] && bul_en && (bul_data != 4'd0))  color_d = bul_data;
    else if (hit2_q[H_CHAR] && (char_data != 4'd0))          color_d = char_data;
    else if (hit2_q[H_MON] && (mon_data != 4'd0))            color_d = mon_data;
    else if (hit2_q[H_KEY] && key_en && (key_data != 4'd0))  color_d = key_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bg_addr_q <= '0;
      ch_addr_q <= '0;
      mn_addr_q <= '0;
      ky_addr_q <= '0;
      bl_addr_q <= '0;
      hit1_q    <= '0;
      vld1_q    <= 1'b0;
      hit2_q    <= '0;
      vld2_q    <= 1'b0;
      color_q   <= '0;
      pvo_q     <= 1'b0;
    end else begin
      bg_addr_q <= {10'd0, DrawY[9:1]} * 19'd320 + {10'd0, DrawX[9:1]};
      ch_addr_q <= hit_s[H_CHAR] ? spr_off(DrawX, DrawY, char_x, char_y, 19'd35) : '0;
      mn_addr_q <= hit_s[H_MON]  ? spr_off(DrawX, DrawY, mon_x,  mon_y,  19'd35) : '0;
      ky_addr_q <= hit_s[H_KEY]  ? spr_off(DrawX, DrawY, key_x,  key_y,  19'd35) : '0;
      bl_addr_q <= hit_s[H_BUL]  ? spr_off(DrawX, DrawY, bul_x,  bul_y,  19'd5)  : '0;
      hit1_q    <= hit_s;
      vld1_q    <= pix_valid;
      hit2_q    <= hit1_q;
      vld2_q    <= vld1_q;
      color_q   <= color_d;
      pvo_q     <= vld2_q;
    end
  end

  assign bg_addr       = bg_addr_q;
  assign char_addr     = ch_addr_q;
  assign mon_addr      = mn_addr_q;
  assign key_addr      = ky_addr_q;
  assign bul_addr      = bl_addr_q;
  assign screen_sel    = sel_q;
  assign char_frame    = cf_q;
  assign color_idx     = color_q;
  assign pix_valid_out = pvo_q;
  assign mode          = mode_q;

endmodule
